// File: rtl/mem_arb_np_pkg.sv
// rtl/mem_arb_np_pkg.sv - shared state encoding and width defaults for the memory arbiter
package mem_arb_np_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;

    // Width of a port index; never below one bit so a 1-bit pointer still exists.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_np_arb_pick.sv
// rtl/mem_arb_np_arb_pick.sv - combinational fixed-priority / round-robin winner picker
module arb_pick
    import mem_arb_np_pkg::*;
#(
    parameter int NPORT = 2,
    localparam int PW   = ptr_w(NPORT)
) (
    input  logic [NPORT-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic             rr_mode_i,
    output logic [NPORT-1:0] gnt_o,
    output logic [PW-1:0]    idx_o,
    output logic             any_o
);

    // Search starts at the pointer in round-robin mode, at port 0 otherwise, and wraps.
    always_comb begin
        int          start_idx;
        logic [PW-1:0] j;
        logic        found;
        start_idx = rr_mode_i ? int'(ptr_i) : 0;
        j         = '0;
        found     = 1'b0;
        gnt_o     = '0;
        idx_o     = '0;
        for (int i = 0; i < NPORT; i++) begin
            j = PW'((start_idx + i) % NPORT);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mem_arb_np.sv
// rtl/mem_arb_np.sv - N-port single-outstanding memory arbiter onto one downstream port
module mem_arb_np
    import mem_arb_np_pkg::*;
#(
    parameter int NPORT   = 2,
    parameter int AW      = ADDR_W,
    parameter int DW      = XLEN,
    parameter int MW      = DW / 8,
    parameter int RR_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req_valid_i,
    output logic [NPORT-1:0]    req_ready_o,
    input  logic [NPORT-1:0]    req_we_i,
    input  logic [NPORT*AW-1:0] req_addr_i,
    input  logic [NPORT*DW-1:0] req_wdata_i,
    input  logic [NPORT*MW-1:0] req_mask_i,
    output logic [NPORT-1:0]    rsp_valid_o,
    output logic [DW-1:0]       rsp_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_wdata_o,
    output logic [MW-1:0]       mem_mask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DW-1:0]       mem_rdata_i
);

    localparam int PW = ptr_w(NPORT);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic              txn_we_q, txn_we_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [MW-1:0]     mem_mask_q, mem_mask_d;
    logic [NPORT-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [NPORT-1:0]  pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;

    arb_pick #(
        .NPORT(NPORT)
    ) u_pick (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .rr_mode_i (RR_MODE != 0),
        .gnt_o     (pick_gnt),
        .idx_o     (pick_idx),
        .any_o     (pick_any)
    );

    // mem_* registers double as the request latch: loaded on accept, zeroed on grant.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        txn_we_d    = txn_we_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        req_ready_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && pick_any) begin
                    req_ready_o = pick_gnt;
                    owner_d     = pick_idx;
                    txn_we_d    = req_we_i[pick_idx];
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we_i[pick_idx];
                    mem_addr_d  = req_addr_i[int'(pick_idx)*AW +: AW];
                    mem_wdata_d = req_wdata_i[int'(pick_idx)*DW +: DW];
                    mem_mask_d  = req_mask_i[int'(pick_idx)*MW +: MW];
                    ptr_d       = (pick_idx == PW'(NPORT - 1)) ? '0 : pick_idx + PW'(1);
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_mask_d  = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = txn_we_q ? '0 : mem_rdata_i;
                    state_d              = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            txn_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            txn_we_q    <= txn_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_mask_o  = mem_mask_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: doc/mem_arb_np.md
Name: mem_arb_np

Overview:
- N-port memory arbiter. Merges NPORT requester channels (fetch, load/store, DMA, ...) onto one downstream memory port.
- Each channel carries read and write; only one transaction is outstanding at a time.
- Priority is fixed or round-robin, selected by parameter.
- Sits between pipeline/cache requesters and the memory backend (DPI shim or bus bridge).

Parameters:
- NPORT, 2, number of requester channels (2..8).
- AW, 32, address width.
- DW, 64, data width (XLEN).
- MW, 8, byte-mask width (DW/8).
- RR_MODE, 0, 0 = fixed priority (port 0 highest); 1 = round-robin.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  NPORT  per-port request valid.
- req_ready_o  out  NPORT  per-port accept pulse.
- req_we_i  in  NPORT  per-port write enable (1 = write).
- req_addr_i  in  NPORT*AW  packed addresses; port k at [k*AW +: AW].
- req_wdata_i  in  NPORT*DW  packed write data.
- req_mask_i  in  NPORT*MW  packed byte masks.
- rsp_valid_o  out  NPORT  per-port response pulse.
- rsp_rdata_o  out  DW  shared response data, qualified by rsp_valid_o.
- mem_req_o  out  1  downstream request.
- mem_we_o  out  1  downstream write enable.
- mem_addr_o  out  AW  downstream address.
- mem_wdata_o  out  DW  downstream write data.
- mem_mask_o  out  MW  downstream byte mask.
- mem_gnt_i  in  1  downstream accepts the request.
- mem_rvalid_i  in  1  downstream completion; read data valid.
- mem_rdata_i  in  DW  downstream read data.

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, the arbiter picks winner g.
  - req_ready_o[g]=1 is asserted combinationally in the same cycle.
  - we/addr/wdata/mask of port g and owner=g are latched.
  - Next state is REQ. If no port is valid, stay in IDLE.
- REQ:
  - mem_req_o=1 and the mem_* fields are driven from the latched registers, stable until grant.
  - When mem_gnt_i=1, go to WAIT and drop mem_req_o next cycle.
- WAIT:
  - When mem_rvalid_i=1, capture mem_rdata_i (write transactions capture 0) and go to RESP.
- RESP:
  - rsp_valid_o[owner]=1 for exactly one cycle, with rsp_rdata_o = captured data.
  - Next state is IDLE.
  - A new accept cannot occur in the RESP cycle.
- Minimum latency with gnt the same cycle as req and rvalid the next cycle:
  - accept at cycle T, mem_req_o at T+1, rvalid at T+2, rsp_valid_o at T+3.
  - Next accept at T+4.
- Requester rules:
  - A requester holds valid and all fields stable until its req_ready_o.
  - A requester may drop valid only after accept.
  - req_ready_o is never asserted outside IDLE.
- Fixed priority: lowest valid index wins.
- Round-robin:
  - Pointer p (reset 0); the search starts at p and wraps NPORT-1 -> 0.
  - On accept of g, p <= (g+1) mod NPORT.
  - A continuously valid port is accepted within NPORT accepts.
- Simultaneous events and stray inputs:
  - mem_rvalid_i is sampled only in WAIT; in IDLE, REQ or RESP it is ignored.
  - mem_gnt_i outside REQ is ignored.
  - Requests arriving while busy wait; this is not an error.
- Reset values: all outputs 0 (req_ready_o, rsp_valid_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mask_o, rsp_rdata_o), state IDLE, p=0, owner=0.
- Reset mid-operation:
  - The in-flight transaction is abandoned.
  - mem_req_o is 0 from the cycle after rst is sampled.
  - Any later rvalid for the abandoned transaction is ignored, because the state is IDLE.
- mem_* outputs are zero whenever the state is not REQ.
- rsp_rdata_o is zero whenever no rsp_valid_o bit is set.

Decomposition:
- Shared package/header (sysconfig.v): state encoding constants (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3), plus XLEN/address-width defaults.
- Sub-module arb_pick: NPORT-parametrised, combinational.
  - Inputs: req vector, pointer, RR_MODE.
  - Outputs: one-hot grant and binary index.
- The top holds the FSM, pointer and latches.

Test Plan:
1. NPORT=2, fixed mode, port 0 and port 1 valid together, gnt tied 1, rvalid one cycle after gnt -> port 0 accepted first (ready at T, rsp_valid_o[0] at T+3); port 1 accepted at T+4.
2. RR_MODE=1, NPORT=4, all ports valid continuously for 8 transactions -> accept order 0,1,2,3,0,1,2,3.
3. Port 1 write: addr 0x80000010, wdata 0xDEADBEEF_CAFEF00D, mask 0x0F, gnt delayed 3 cycles -> mem_req_o high for 4 cycles with stable fields; rsp_valid_o[1] with rsp_rdata_o=0.
4. Read with rvalid 5 cycles after gnt, mem_rdata_i=0x1234 -> only rsp_valid_o[owner] pulses, for one cycle, rsp_rdata_o=0x1234; other bits stay 0.
5. rst asserted in WAIT, then rvalid pulses after reset -> no rsp_valid_o; all outputs 0; the next request is accepted normally from IDLE.
6. Stray mem_rvalid_i in IDLE and in REQ -> ignored; the REQ transaction still completes on its own later rvalid.
